gate_event_counter: RTL and testbench
=====================================

# gate_event_counter

Downstream consumer of the sync/gate sequencer's `Sync`/`Gate`/`Done` strobes. Counts rising edges on an event input during each gate window and queues one result per window (count plus overflow flag) in a small FIFO. A valid/ready interface drains the FIFO. Sits between the timing sequencer and the measurement readout logic.

## Interface
- `CNT_W`, 16: result counter width.
- `DEPTH`, 4: result FIFO depth (power of two, ≥2).
- `DROP_W`, 8: dropped-result counter width.

- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-low reset.
- `ena` in 1: count/FSM enable; low freezes the FSM and the counter only.
- `sync` in 1: window-arm strobe from the sequencer.
- `gate` in 1: window-open level from the sequencer.
- `done` in 1: window-complete strobe from the sequencer.
- `evt_in` in 1: event input, already synchronous to `clk`.
- `res_data` out CNT_W: FIFO head count.
- `res_ovf` out 1: FIFO head overflow flag.
- `res_valid` out 1: FIFO non-empty.
- `res_ready` in 1: consumer accept.
- `busy` out 1: FSM not in IDLE.
- `drop_cnt` out DROP_W: results lost to a full FIFO; saturates at all-ones.

## Operation
- FSM states: IDLE, ARMED, COUNT, HOLD. All transitions require `ena`=1. Exception: `rst`.
- IDLE → ARMED on `sync`. Clears the counter and the ovf flag.
- ARMED → COUNT on `gate`=1. `sync` in ARMED re-clears the counter and stays in ARMED.
- COUNT → HOLD on `gate`=0.
- COUNT: `sync` aborts the window. Clear the counter, go to ARMED, no push.
- HOLD → IDLE on `done`, with a push.
- `done` in ARMED pushes count 0 (covers a zero-length gate), then IDLE.
- `done` in COUNT pushes the count, including any edge in that cycle, then IDLE.
- `done` in IDLE is ignored.
- `sync` and `done` in the same cycle: `done` wins. Then `sync` is honoured from IDLE on the next cycle only if it is reasserted.
- Edge detect: `evt_prev` is registered every cycle, regardless of `ena` or state. An edge is `evt_in & ~evt_prev`.
- Count increments only in COUNT with `ena`=1.
- Count saturates at 2^CNT_W−1. Any further edge sets the sticky ovf flag.
- FIFO push with a simultaneous pop is always accepted.
- Push while full with no pop: the result is discarded and `drop_cnt` increments (saturating).
- Pop occurs when `res_valid & res_ready`. `res_ready` with an empty FIFO has no effect.
- The FIFO handshake is independent of `ena`.

## Timing
- Reset values:
  - state IDLE, counter 0, ovf 0, `evt_prev` 0.
  - FIFO empty, `res_valid` 0, `res_data` 0, `res_ovf` 0.
  - `busy` 0, `drop_cnt` 0.
- Reset mid-window discards the in-flight count and all queued results.
- `busy` is registered. It rises the cycle after `sync` is accepted and falls the cycle after the push.
- Push latency: `done` sampled at edge t → entry written at t; `res_valid`=1 from t+1 if the FIFO was empty.
- `res_data`/`res_ovf` are stable while `res_valid`=1 and `res_ready`=0.
- After a pop at edge t, the next entry is presented from t+1. Back-to-back pops drain one entry per cycle.
- An `evt_in` edge present in the same cycle as the ARMED→COUNT transition is not counted. Counting starts the cycle after `gate` is sampled high.

## Structure
- Package `gate_cnt_pkg`:
  - state enum `gc_state_e` {IDLE, ARMED, COUNT, HOLD}.
  - default width constants.
  - packed result struct {ovf, count}.
- Sub-module `result_fifo`: parameterised sync FIFO of the result struct with full/empty, push/pop and simultaneous-access rule. Registered head output.
- FSM, edge detect, counter and drop counter live in `gate_event_counter`.

## Test plan
- Basic window: `sync`; `gate` high 10 cycles; 3 `evt_in` pulses inside the window, 2 outside; `done`. Expect one entry {count 3, ovf 0}. `res_valid` rises the cycle after `done`.
- Saturation: CNT_W=4, 20 edges in one window. Expect count 15, ovf 1.
- Abort: `sync`, `gate` high, 5 edges, `sync` again while `gate` is high, `gate` low, 2 more edges in a new gate, `done`. Expect a single entry with count 2.
- FIFO full: DEPTH=4, `res_ready`=0, 6 windows. Expect 4 entries held and `drop_cnt`=2. Then a 7th window with `res_ready`=1 on the `done` cycle: push accepted, `drop_cnt` stays 2.
- Freeze and reset: `ena`=0 mid-COUNT with 4 edges: count unchanged, FIFO drains normally. Then `rst`=0 for 1 cycle mid-window: all outputs at reset values next cycle; a subsequent `done` is ignored.
- Zero gate: `sync` then `done` with no `gate`. Expect entry {count 0, ovf 0}, `busy` low the following cycle.

Source files
------------

// File: rtl/gate_cnt_pkg.sv
// Shared types and default widths for the gate event counter and its result FIFO.
package gate_cnt_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int DROP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COUNT,
    HOLD
  } gc_state_e;

  typedef struct packed {
    logic                 ovf;
    logic [CNT_W_DEF-1:0] count;
  } gc_result_t;

endpackage

// File: rtl/gate_event_counter_if.sv
// Valid/ready result stream from the gate event counter to the readout logic.
interface gate_event_counter_if
  import gate_cnt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic [CNT_W-1:0] res_data;
  logic             res_ovf;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output res_data,
    output res_ovf,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_ovf,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/result_fifo.sv
// Synchronous result FIFO with a registered head; a push alongside a pop is
// always accepted, even when full.
module result_fifo
  import gate_cnt_pkg::*;
#(
  parameter type T     = gc_result_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic valid,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  T              head_reg, head_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   level_reg, level_kept, level_next;
  logic          pop_acc, push_acc;

  assign pop_acc     = pop & (level_reg != '0);
  assign full        = (level_reg == FULL_LVL);
  assign push_acc    = push & (~full | pop_acc);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop_acc);
  assign level_kept  = level_reg - (AW+1)'(pop_acc);
  assign level_next  = level_kept + (AW+1)'(push_acc);

  // Head shows the oldest surviving entry; an empty FIFO forwards the write.
  always_comb begin
    head_next = head_reg;
    if (level_kept != '0) begin
      head_next = mem[rd_ptr_next];
    end else if (push_acc) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_acc);
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      head_reg   <= head_next;
    end
  end

  assign head  = head_reg;
  assign valid = (level_reg != '0);

endmodule

// File: rtl/gate_event_counter.sv
// Counts rising event edges per gate window and queues one {ovf, count} result
// per completed window for a valid/ready consumer.
module gate_event_counter
  import gate_cnt_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 sync,
  input  logic                 gate,
  input  logic                 done,
  input  logic                 evt_in,
  gate_event_counter_if.master res,
  output logic                 busy,
  output logic [DROP_W-1:0]    drop_cnt
);
  typedef struct packed {
    logic             ovf;
    logic [CNT_W-1:0] count;
  } res_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  gc_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic              ovf_reg, ovf_next, ovf_inc;
  logic              evt_prev_reg, busy_reg, evt_edge;
  logic [DROP_W-1:0] drop_reg;
  logic              push, pop, fifo_valid, fifo_full;
  res_t              push_data, head;

  assign evt_edge = evt_in & ~evt_prev_reg;

  // Saturating increment; edges past the maximum only set the sticky flag.
  always_comb begin
    cnt_inc = cnt_reg;
    ovf_inc = ovf_reg;
    if (evt_edge) begin
      if (cnt_reg == CNT_MAX) begin
        ovf_inc = 1'b1;
      end else begin
        cnt_inc = cnt_reg + 1'b1;
      end
    end
  end

  // done outranks sync, which outranks gate, in every state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    push       = 1'b0;
    push_data  = '{ovf: ovf_reg, count: cnt_reg};
    if (ena) begin
      case (state_reg)
        IDLE: begin
          if (sync) begin
            state_next = ARMED;
            cnt_next   = '0;
            ovf_next   = 1'b0;
          end
        end
        ARMED: begin
          if (done) begin
            push       = 1'b1;
            push_data  = '{ovf: 1'b0, count: '0};
            state_next = IDLE;
          end else if (sync) begin
            cnt_next = '0;
            ovf_next = 1'b0;
          end else if (gate) begin
            state_next = COUNT;
          end
        end
        COUNT: begin
          if (done) begin
            push       = 1'b1;
            push_data  = '{ovf: ovf_inc, count: cnt_inc};
            state_next = IDLE;
          end else if (sync) begin
            cnt_next   = '0;
            ovf_next   = 1'b0;
            state_next = ARMED;
          end else begin
            cnt_next = cnt_inc;
            ovf_next = ovf_inc;
            if (!gate) begin
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (done) begin
            push       = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      evt_prev_reg <= 1'b0;
      busy_reg     <= 1'b0;
      drop_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      evt_prev_reg <= evt_in;
      busy_reg     <= (state_next != IDLE);
      if (push & fifo_full & ~pop & (drop_reg != DROP_MAX)) begin
        drop_reg <= drop_reg + 1'b1;
      end
    end
  end

  result_fifo #(
    .T     (res_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full)
  );

  assign pop           = fifo_valid & res.res_ready;
  assign res.res_valid = fifo_valid;
  assign res.res_data  = head.count;
  assign res.res_ovf   = head.ovf;
  assign busy          = busy_reg;
  assign drop_cnt      = drop_reg;

endmodule

// File: tb/tb_gate_event_counter.sv
// Directed and randomized windows checked against a window-level scoreboard of edge totals.
module tb_gate_event_counter;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int CMAX   = 15;
  localparam int DMAX   = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b1;
  logic sync = 1'b0;
  logic gate = 1'b0;
  logic done = 1'b0;
  logic evt_in = 1'b0;
  logic busy;
  logic [DROP_W-1:0] drop_cnt;

  gate_event_counter_if #(.CNT_W(CNT_W)) bus ();

  gate_event_counter #(
    .CNT_W  (CNT_W),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .sync     (sync),
    .gate     (gate),
    .done     (done),
    .evt_in   (evt_in),
    .res      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int q[$];            // queued results, as raw edge totals per window
  int m_edges = 0;
  int m_drop = 0;
  bit evt_prev_m = 1'b0;
  int evt_pct = 50;
  int ready_mode = 0;  // 0 never, 1 always, 2 random, 3 only with done
  bit evt_script[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int e);
    return (e > CMAX) ? CMAX : e;
  endfunction

  task automatic drive(input bit s, input bit g, input bit d);
    sync = s;
    gate = g;
    done = d;
    if (evt_script.size() != 0) evt_in = evt_script.pop_front();
    else evt_in = (int'($urandom_range(0, 99)) < evt_pct);
    case (ready_mode)
      0:       bus.res_ready = 1'b0;
      1:       bus.res_ready = 1'b1;
      2:       bus.res_ready = 1'($urandom_range(0, 1));
      default: bus.res_ready = d;
    endcase
  endtask

  // One clock: check the stream before the edge, update the model, check state after.
  task automatic tick(input bit count_here, input bit push_here, input bit busy_after);
    bit edge_now;
    bit exp_busy;
    edge_now = evt_in & ~evt_prev_m;
    chk("valid", 32'(bus.res_valid), 32'(q.size() != 0));
    if (q.size() != 0 && bus.res_ready === 1'b1) begin
      chk("head_cnt", 32'(bus.res_data), 32'(sat(q[0])));
      chk("head_ovf", 32'(bus.res_ovf), 32'(q[0] > CMAX));
      void'(q.pop_front());
    end
    if (count_here && ena && edge_now) m_edges++;
    if (push_here) begin
      if (q.size() < DEPTH) q.push_back(m_edges);
      else if (m_drop < DMAX) m_drop++;
    end
    exp_busy = busy_after;
    if (!rst) begin
      q.delete();
      m_drop = 0;
      m_edges = 0;
      exp_busy = 1'b0;
    end
    evt_prev_m = rst ? evt_in : 1'b0;
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0);
      tick(0, 0, 0);
    end
  endtask

  // hold_len 0 ends with done in the gate-low cycle (still counting);
  // gate_len 0 ends with done while armed.
  task automatic run_window(input int pre_gate, input int gate_len, input int hold_len);
    drive(1, 0, 0);
    m_edges = 0;
    tick(0, 0, 1);
    for (int i = 0; i < pre_gate; i++) begin
      drive((i > 0) && ($urandom_range(0, 3) == 0), 0, 0);
      tick(0, 0, 1);
    end
    if (gate_len == 0) begin
      drive(0, 0, 1);
      tick(0, 1, 0);
    end else begin
      for (int i = 0; i < gate_len; i++) begin
        drive(0, 1, 0);
        tick(i > 0, 0, 1);
      end
      if (hold_len == 0) begin
        drive(0, 0, 1);
        tick(1, 1, 0);
      end else begin
        drive(0, 0, 0);
        tick(1, 0, 1);
        for (int i = 1; i < hold_len; i++) begin
          drive(0, 0, 0);
          tick(0, 0, 1);
        end
        drive(0, 0, 1);
        tick(0, 1, 0);
      end
    end
  endtask

  initial begin
    bus.res_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.res_valid), 32'(0));
    chk("rst_data", 32'(bus.res_data), 32'(0));
    chk("rst_ovf", 32'(bus.res_ovf), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_drop", 32'(drop_cnt), 32'(0));
    rst = 1'b1;
    idle(2);

    // basic window: 3 edges inside the gate, 2 outside
    evt_script = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    run_window(1, 10, 2);
    chk("basic_valid", 32'(bus.res_valid), 32'(1));
    chk("basic_cnt", 32'(bus.res_data), 32'(3));
    chk("basic_ovf", 32'(bus.res_ovf), 32'(0));
    ready_mode = 1;
    idle(2);

    // saturation: 20 edges into a 4-bit counter
    ready_mode = 0;
    evt_script = '{0, 0};
    for (int i = 0; i < 41; i++) evt_script.push_back(1'(i % 2));
    evt_script.push_back(0);
    evt_script.push_back(0);
    run_window(1, 41, 1);
    chk("sat_cnt", 32'(bus.res_data), 32'(15));
    chk("sat_ovf", 32'(bus.res_ovf), 32'(1));
    ready_mode = 1;
    idle(2);

    // abort by sync mid-gate, then a fresh gate with 2 edges
    ready_mode = 0;
    evt_script = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    drive(1, 0, 0); m_edges = 0; tick(0, 0, 1);
    drive(0, 1, 0); tick(0, 0, 1);
    for (int i = 0; i < 10; i++) begin drive(0, 1, 0); tick(1, 0, 1); end
    drive(1, 1, 0); m_edges = 0; tick(0, 0, 1);
    drive(0, 0, 0); tick(0, 0, 1);
    drive(0, 1, 0); tick(0, 0, 1);
    for (int i = 0; i < 4; i++) begin drive(0, 1, 0); tick(1, 0, 1); end
    drive(0, 0, 0); tick(1, 0, 1);
    drive(0, 0, 1); tick(0, 1, 0);
    chk("abort_cnt", 32'(bus.res_data), 32'(2));
    ready_mode = 1;
    idle(2);

    // FIFO full: six windows with no consumer, then a push alongside a pop
    ready_mode = 0;
    evt_pct = 40;
    for (int w = 0; w < 6; w++) begin run_window(0, 4, 1); idle(1); end
    chk("full_drop", 32'(drop_cnt), 32'(2));
    chk("full_valid", 32'(bus.res_valid), 32'(1));
    ready_mode = 3;
    run_window(0, 4, 1);
    chk("full_drop_kept", 32'(drop_cnt), 32'(2));
    ready_mode = 1;
    idle(6);

    // freeze mid-count while the FIFO drains
    ready_mode = 0;
    run_window(0, 3, 1);
    run_window(0, 3, 1);
    evt_script = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0};
    drive(1, 0, 0); m_edges = 0; tick(0, 0, 1);
    drive(0, 1, 0); tick(0, 0, 1);
    for (int i = 0; i < 2; i++) begin drive(0, 1, 0); tick(1, 0, 1); end
    ena = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin drive(0, 1, 0); tick(1, 0, 1); end
    ena = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0); tick(1, 0, 1); end
    drive(0, 0, 0); tick(1, 0, 1);
    drive(0, 0, 1); tick(0, 1, 0);
    chk("freeze_cnt", 32'(bus.res_data), 32'(2));
    chk("freeze_valid", 32'(bus.res_valid), 32'(1));

    // reset mid-window discards everything; the later done is ignored
    drive(1, 0, 0); m_edges = 0; tick(0, 0, 1);
    drive(0, 1, 0); tick(0, 0, 1);
    for (int i = 0; i < 2; i++) begin drive(0, 1, 0); tick(1, 0, 1); end
    rst = 1'b0;
    drive(0, 1, 0); tick(0, 0, 0);
    rst = 1'b1;
    chk("mrst_valid", 32'(bus.res_valid), 32'(0));
    chk("mrst_data", 32'(bus.res_data), 32'(0));
    chk("mrst_ovf", 32'(bus.res_ovf), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_drop", 32'(drop_cnt), 32'(0));
    drive(0, 0, 0); tick(0, 0, 0);
    drive(0, 0, 1); tick(0, 0, 0);
    chk("mrst_done_ignored", 32'(bus.res_valid), 32'(0));

    // zero-length gate
    run_window(2, 0, 0);
    chk("zero_valid", 32'(bus.res_valid), 32'(1));
    chk("zero_cnt", 32'(bus.res_data), 32'(0));
    chk("zero_ovf", 32'(bus.res_ovf), 32'(0));
    chk("zero_busy", 32'(busy), 32'(0));
    ready_mode = 1;
    idle(2);

    // done with sync in COUNT: done wins, its own edge counts, sync not carried over
    evt_script = '{0, 0, 1, 0, 1, 0, 0};
    drive(1, 0, 0); m_edges = 0; tick(0, 0, 1);
    drive(0, 1, 0); tick(0, 0, 1);
    drive(0, 1, 0); tick(1, 0, 1);
    drive(0, 1, 0); tick(1, 0, 1);
    drive(1, 1, 1); tick(1, 1, 0);
    idle(2);

    // randomized windows with a random consumer
    ready_mode = 2;
    for (int w = 0; w < 25; w++) begin
      evt_pct = int'($urandom_range(10, 90));
      run_window(int'($urandom_range(0, 3)), int'($urandom_range(0, 30)), int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 3)));
    end
    ready_mode = 1;
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
